// File: rtl/data_memory_responder_if.sv
// Data memory bus between the load/store unit (master) and the data RAM
// responder (slave).
//   mem_address          byte address of the access
//   mem_write_en         store byte enables, left-justified (1000/1100/1111)
//   mem_write_data       store data, left-justified (byte 0 in bits 31:24)
//   mem_read_en          load byte enables, same encoding as mem_write_en
//   mem_read_data        load result, right-justified, upper bits zero
//   mem_read_data_valid  one-cycle pulse qualifying mem_read_data
//   mem_busy             responder cannot accept a request this cycle
interface data_memory_responder_if;
    logic [31:0] mem_address;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_read_en;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        mem_busy;

    modport master (
        output mem_address,
        output mem_write_en,
        output mem_write_data,
        output mem_read_en,
        input  mem_read_data,
        input  mem_read_data_valid,
        input  mem_busy
    );

    modport slave (
        input  mem_address,
        input  mem_write_en,
        input  mem_write_data,
        input  mem_read_en,
        output mem_read_data,
        output mem_read_data_valid,
        output mem_busy
    );
endinterface

// File: rtl/data_memory_responder.sv
// Responder for the load/store unit's data memory bus. Owns a single-port,
// word-organised, big-endian RAM of 2^ADDR_WIDTH 32-bit words. Byte,
// halfword and word accesses may start at any byte address; an access that
// runs past the end of a word is split into two RAM cycles, stalling the
// initiator with mem_busy for the second one. Load data is returned
// right-justified READ_LATENCY cycles after the final RAM cycle.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (RAM contents are not cleared)
//   bus   data_memory_responder_if slave modport
// Parameters:
//   ADDR_WIDTH    log2 of RAM depth in words (at most 29)
//   READ_LATENCY  final access cycle to valid pulse, at least 1
// Byte lane 0 of a word (lowest byte address) sits in bits 31:24.
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    data_memory_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;

    logic [31:0] mem [DEPTH];

    // Request decode
    logic                  req_write;
    logic [3:0]            req_en;
    logic [2:0]            req_k;
    logic                  req_legal;
    logic [1:0]            req_lane;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_cross;
    logic [63:0]           req_wdata;
    logic [7:0]            req_wmask;
    logic                  unused_addr;

    // Context captured at the first half of a split access
    logic                  sec_write_q;
    logic [ADDR_WIDTH-1:0] sec_idx_q;
    logic [31:0]           sec_wdata_q;
    logic [3:0]            sec_wmask_q;
    logic [1:0]            sec_lane_q;
    logic [2:0]            sec_k_q;
    logic [31:0]           hold_q;

    // RAM port and read assembly
    logic                  acc_write;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_wmask;
    logic [31:0]           acc_rdata;
    logic                  split_start;
    logic                  rd_push;
    logic [1:0]            rd_lane;
    logic [2:0]            rd_k;
    logic [63:0]           rd_pair;
    logic [5:0]            rd_base;
    logic [31:0]           rd_window;
    logic [31:0]           rd_result;

    // Read response pipeline; the last stage drives the bus outputs
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_data [READ_LATENCY];

    // Decode the request on the bus; a nonzero write enable takes precedence.
    // Data and lane mask are pre-shifted into a two-word window so the upper
    // half lands in the first word and the lower half in the next word.
    always_comb begin
        req_write = |bus.mem_write_en;
        req_en    = req_write ? bus.mem_write_en : bus.mem_read_en;
        case (req_en)
            4'b1000: req_k = 3'd1;
            4'b1100: req_k = 3'd2;
            4'b1111: req_k = 3'd4;
            default: req_k = 3'd0;
        endcase
        req_legal = (req_k != 3'd0);
        req_lane  = bus.mem_address[1:0];
        req_idx   = bus.mem_address[ADDR_WIDTH+1:2];
        req_cross = (({1'b0, req_lane} + req_k) > 3'd4);
        req_wdata = {bus.mem_write_data, 32'd0} >> {req_lane, 3'b000};
        req_wmask = {req_en, 4'd0} >> req_lane;
    end

    // Address bits above the RAM are ignored so accesses wrap.
    assign unused_addr = ^bus.mem_address[31:ADDR_WIDTH+2];

    // FSM state and busy register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Next state and RAM port control
    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        acc_write   = 1'b0;
        acc_idx     = req_idx;
        acc_wdata   = req_wdata[63:32];
        acc_wmask   = req_wmask[7:4];
        split_start = 1'b0;
        rd_push     = 1'b0;
        rd_lane     = req_lane;
        rd_k        = req_k;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_legal) begin
                        acc_write = req_write;
                        if (req_cross) begin
                            split_start = 1'b1;
                            state_d     = ST_SECOND;
                            busy_d      = 1'b1;
                        end else begin
                            rd_push = !req_write;
                        end
                    end
                end
                ST_SECOND: begin
                    acc_write = sec_write_q;
                    acc_idx   = sec_idx_q;
                    acc_wdata = sec_wdata_q;
                    acc_wmask = sec_wmask_q;
                    rd_lane   = sec_lane_q;
                    rd_k      = sec_k_q;
                    rd_push   = !sec_write_q;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Second-half context; the first word read is held for merging.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_write_q <= 1'b0;
            sec_idx_q   <= '0;
            sec_wdata_q <= '0;
            sec_wmask_q <= '0;
            sec_lane_q  <= '0;
            sec_k_q     <= '0;
            hold_q      <= '0;
        end else if (split_start) begin
            sec_write_q <= req_write;
            sec_idx_q   <= req_idx + ADDR_WIDTH'(1);
            sec_wdata_q <= req_wdata[31:0];
            sec_wmask_q <= req_wmask[3:0];
            sec_lane_q  <= req_lane;
            sec_k_q     <= req_k;
            hold_q      <= acc_rdata;
        end
    end

    // RAM byte-lane writes
    always_ff @(posedge clk) begin
        if (acc_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read assembly: pick the k addressed bytes out of the two-word window,
    // then right-justify them.
    always_comb begin
        acc_rdata = mem[acc_idx];
        rd_pair   = (state_q == ST_SECOND) ? {hold_q, acc_rdata} : {acc_rdata, 32'd0};
        rd_base   = 6'd32 - {1'b0, rd_lane, 3'b000};
        rd_window = rd_pair[rd_base +: 32];
        rd_result = rd_window >> (6'd32 - {rd_k, 3'b000});
    end

    // Response pipeline; data stages only load with a valid entry so the
    // output holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int s = 0; s < int'(READ_LATENCY); s++) begin
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_push;
            if (rd_push) begin
                pipe_data[0] <= rd_result;
            end
            for (int s = 1; s < int'(READ_LATENCY); s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign bus.mem_read_data       = pipe_data[READ_LATENCY-1];
    assign bus.mem_read_data_valid = pipe_vld[READ_LATENCY-1];
    assign bus.mem_busy            = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: a directed vector table,
// a reset-during-split sequence, and random traffic checked against a
// byte-array reference memory.
module tb_data_memory_responder;
    localparam int unsigned AW = 6;
    localparam int unsigned RL = 2;
    localparam int NB = 4 * (1 << AW);

    logic clk = 1'b0;
    logic rst;

    data_memory_responder_if bus();

    data_memory_responder #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        logic [31:0] full;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [3:0]  ren;
        bit          resp;
        logic [31:0] exp;
        logic [31:0] mask;
        int          lat;
        bit          split;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          exp_busy = 1'b0;
    bit          pending_busy = 1'b0;
    logic [31:0] last_data = 32'd0;
    logic [7:0]  ref_mem [NB];
    resp_t       rq[$];
    vec_t        tab[$];
    logic [3:0]  illegal [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int kof(input logic [3:0] en);
        case (en)
            4'b1000: return 1;
            4'b1100: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        bit due_now;
        due_now = (rq.size() != 0) && (rq[0].due == cyc);
        chk("busy", {31'd0, bus.mem_busy}, {31'd0, exp_busy});
        chk("read_valid", {31'd0, bus.mem_read_data_valid}, {31'd0, due_now});
        if (due_now) begin
            if (bus.mem_read_data_valid)
                chk("read_data", bus.mem_read_data & rq[0].mask, rq[0].exp & rq[0].mask);
            last_data = rq[0].full;
            void'(rq.pop_front());
        end else if (!bus.mem_read_data_valid) begin
            chk("data_hold", bus.mem_read_data, last_data);
        end
        while (rq.size() != 0 && rq[0].due < cyc) void'(rq.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        exp_busy = pending_busy;
        pending_busy = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_address    = 32'd0;
            bus.mem_write_en   = 4'd0;
            bus.mem_write_data = 32'd0;
            bus.mem_read_en    = 4'd0;
            step();
        end
    endtask

    // Reference behaviour: byte j of a request touches byte address A+j.
    task automatic model_access(input logic [31:0] addr, input logic [3:0] wen,
                                input logic [31:0] wdata, input logic [3:0] ren,
                                output bit push, output logic [31:0] res, output bit split);
        int k;
        int a;
        k = 0;
        push = 1'b0;
        res = 32'd0;
        if (wen != 4'd0) begin
            k = kof(wen);
            for (int j = 0; j < k; j++) begin
                a = int'((addr + 32'(j)) & 32'(NB - 1));
                ref_mem[a] = wdata[31 - 8*j -: 8];
            end
        end else if (ren != 4'd0) begin
            k = kof(ren);
            for (int j = 0; j < k; j++) begin
                a = int'((addr + 32'(j)) & 32'(NB - 1));
                res = {res[23:0], ref_mem[a]};
            end
            push = (k != 0);
        end
        split = (k != 0) && (int'(addr[1:0]) + k > 4);
    endtask

    // Drive one request; a split request is held through its busy cycle.
    task automatic req(input vec_t v, input bit use_tab);
        bit          push;
        bit          split;
        logic [31:0] res;
        resp_t       e;
        bus.mem_address    = v.addr;
        bus.mem_write_en   = v.wen;
        bus.mem_write_data = v.wdata;
        bus.mem_read_en    = v.ren;
        model_access(v.addr, v.wen, v.wdata, v.ren, push, res, split);
        e.full = res;
        if (use_tab) begin
            if (v.resp) begin
                e.exp  = v.exp;
                e.mask = v.mask;
                e.due  = cyc + v.lat;
                rq.push_back(e);
            end
            pending_busy = v.split;
        end else begin
            if (push) begin
                e.exp  = res;
                e.mask = 32'hFFFF_FFFF;
                e.due  = cyc + int'(RL) + (split ? 1 : 0);
                rq.push_back(e);
            end
            pending_busy = split;
        end
        step();
        if (exp_busy) step();
    endtask

    task automatic tv(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                      input logic [3:0] ren, input bit resp, input logic [31:0] exp,
                      input logic [31:0] mask, input int lat, input bit split);
        vec_t v;
        v.addr = addr; v.wen = wen; v.wdata = wdata; v.ren = ren;
        v.resp = resp; v.exp = exp; v.mask = mask; v.lat = lat; v.split = split;
        tab.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   al;
        int   sl;
        vec_t v;
        al = int'(RL);
        sl = int'(RL) + 1;
        illegal[0] = 4'b0100; illegal[1] = 4'b1010; illegal[2] = 4'b1110;
        illegal[3] = 4'b0001; illegal[4] = 4'b0111;

        // Directed vectors: addr, wen, wdata, ren, resp, expected, mask, latency, split
        tv(32'h10, 4'hF, 32'hDEADBEEF, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h10, 4'h0, 32'h0, 4'hF, 1, 32'hDEADBEEF, 32'hFFFFFFFF, al, 0);
        tv(32'h20, 4'h8, 32'h11000000, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h21, 4'h8, 32'h22000000, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h22, 4'h8, 32'h33000000, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h23, 4'h8, 32'h44000000, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h20, 4'h0, 32'h0, 4'hF, 1, 32'h11223344, 32'hFFFFFFFF, al, 0);
        tv(32'h22, 4'h0, 32'h0, 4'hC, 1, 32'h00003344, 32'hFFFFFFFF, al, 0);
        tv(32'h21, 4'h0, 32'h0, 4'h8, 1, 32'h00000022, 32'hFFFFFFFF, al, 0);
        tv(32'h0E, 4'hF, 32'hAABBCCDD, 4'h0, 0, 32'h0, 32'h0, 0, 1);
        tv(32'h0C, 4'h0, 32'h0, 4'hF, 1, 32'h0000AABB, 32'h0000FFFF, al, 0);
        tv(32'h10, 4'h0, 32'h0, 4'hF, 1, 32'hCCDDBEEF, 32'hFFFFFFFF, al, 0);
        tv(32'h0E, 4'h0, 32'h0, 4'hF, 1, 32'hAABBCCDD, 32'hFFFFFFFF, sl, 1);
        tv(32'(NB - 1), 4'hC, 32'h12340000, 4'h0, 0, 32'h0, 32'h0, 0, 1);
        tv(32'(NB - 1), 4'h0, 32'h0, 4'h8, 1, 32'h00000012, 32'hFFFFFFFF, al, 0);
        tv(32'h00, 4'h0, 32'h0, 4'h8, 1, 32'h00000034, 32'hFFFFFFFF, al, 0);
        tv(32'(NB - 1), 4'h0, 32'h0, 4'hC, 1, 32'h00001234, 32'hFFFFFFFF, sl, 1);
        tv(32'h40, 4'hF, 32'h01020304, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h40, 4'hA, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h40, 4'h0, 32'h0, 4'hA, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h40, 4'h0, 32'h0, 4'hF, 1, 32'h01020304, 32'hFFFFFFFF, al, 0);
        tv(32'h40, 4'hF, 32'h55667788, 4'hF, 0, 32'h0, 32'h0, 0, 0);
        tv(32'h40, 4'h0, 32'h0, 4'hF, 1, 32'h55667788, 32'hFFFFFFFF, al, 0);

        // Reset and RAM initialisation
        rst = 1'b1;
        bus.mem_address = 32'd0; bus.mem_write_en = 4'd0;
        bus.mem_write_data = 32'd0; bus.mem_read_en = 4'd0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < NB / 4; i++) begin
            v.addr = 32'(4 * i); v.wen = 4'hF; v.wdata = $urandom; v.ren = 4'h0;
            v.resp = 0; v.exp = 0; v.mask = 0; v.lat = 0; v.split = 0;
            req(v, 1'b0);
        end

        foreach (tab[i]) req(tab[i], 1'b1);
        idle(int'(RL) + 2);

        // Reset during the second cycle of a split load
        bus.mem_address = 32'h0E; bus.mem_write_en = 4'h0;
        bus.mem_write_data = 32'd0; bus.mem_read_en = 4'hF;
        pending_busy = 1'b1;
        step();
        rst = 1'b1;
        rq.delete();
        last_data = 32'd0;
        step();
        rst = 1'b0;
        idle(int'(RL) + 3);
        v.addr = 32'h10; v.wen = 4'h0; v.wdata = 32'd0; v.ren = 4'hF;
        v.resp = 0; v.exp = 0; v.mask = 0; v.lat = 0; v.split = 0;
        req(v, 1'b0);
        idle(int'(RL) + 2);

        // Random traffic against the reference memory
        for (int n = 0; n < 600; n++) begin
            logic [3:0] en;
            int         op;
            case ($urandom_range(0, 7))
                0, 1:    en = 4'b1000;
                2, 3:    en = 4'b1100;
                4, 5:    en = 4'b1111;
                6:       en = illegal[$urandom_range(0, 4)];
                default: en = 4'b0000;
            endcase
            op = int'($urandom_range(0, 3));
            v.addr  = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, NB - 1));
            v.wen   = (op >= 2) ? en : 4'b0000;
            v.ren   = (op != 2) ? en : 4'b0000;
            v.wdata = $urandom;
            v.resp = 0; v.exp = 0; v.mask = 0; v.lat = 0; v.split = 0;
            req(v, 1'b0);
        end
        idle(int'(RL) + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
